producer_unit: RTL and testbench

- Producer end of the consumer/producer pair inside `top`; generates the data stream the consumer drains.
- Emits an incrementing WIDTH-bit sequence at a programmable rate into a small first-word-fall-through FIFO.
- FIFO head is offered on a valid/ready handshake.
- When the FIFO is full the producer stalls rather than dropping items, so the consumer sees a gap-free sequence.

---
 rtl/producer_unit.sv | 107 ++++++++++
 tb/tb_producer_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/producer_unit.sv
// Incrementing-sequence producer feeding a first-word-fall-through FIFO.
// Stalls on a full FIFO so the consumer sees a gap-free stream.
module producer_unit #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int PERIOD = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       stall
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [TW-1:0]     timer_q;
  logic [TW-1:0]     timer_d;
  logic [WIDTH-1:0]  seq_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic              push;
  logic              pop;
  logic              space;

  assign pop       = out_valid & out_ready;
  // A same-edge pop frees the slot the push needs.
  assign space     = (count_q < CW'(DEPTH)) | pop;
  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = count_q;
  assign stall     = (state_q == STALL);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q != TW'(PERIOD-1)) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = '0;
          if (space) push = 1'b1;
          else       state_d = STALL;
        end
      end
      STALL: begin
        timer_d = '0;
        if (space) begin
          push    = 1'b1;
          state_d = enable ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      seq_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      mem     <= '{default: '0};
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (push) begin
        mem[wr_ptr] <= seq_q;
        wr_ptr      <= wr_ptr + AW'(1);
        seq_q       <= seq_q + WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_producer_unit.sv
// Bench for producer_unit: PERIOD=3 and PERIOD=1 instances against
// a queue-based model, plus directed literal expectations.
module tb_producer_unit;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      en    = '0;
  logic [1:0]      rdy   = '0;
  logic [1:0]      vld;
  logic [1:0]      stl;
  logic [1:0][3:0] dat;
  logic [1:0][2:0] cnt;

  int total = 0;
  int bad   = 0;

  int mq [2][$];
  int mseq  [2];
  int mtick [2];
  bit mrun  [2];
  bit mpend [2];

  always #5 clock = ~clock;

  producer_unit #(.WIDTH(4), .DEPTH(4), .PERIOD(3)) u0 (
    .clock(clock), .reset(reset),
    .enable(en[0]), .out_ready(rdy[0]),
    .out_valid(vld[0]), .out_data(dat[0]),
    .count(cnt[0]), .stall(stl[0])
  );

  producer_unit #(.WIDTH(4), .DEPTH(4), .PERIOD(1)) u1 (
    .clock(clock), .reset(reset),
    .enable(en[1]), .out_ready(rdy[1]),
    .out_valid(vld[1]), .out_data(dat[1]),
    .count(cnt[1]), .stall(stl[1])
  );

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int per(int i);
    return (i == 0) ? 3 : 1;
  endfunction

  task automatic mstep(int i);
    bit pop;
    bit room;
    bit put;
    pop  = (mq[i].size() > 0) && rdy[i];
    room = (mq[i].size() < 4) || pop;
    put  = 1'b0;
    if (mpend[i]) begin
      if (room) begin
        put      = 1'b1;
        mpend[i] = 1'b0;
        mrun[i]  = en[i];
        mtick[i] = 0;
      end
    end else if (mrun[i]) begin
      if (!en[i]) begin
        mrun[i]  = 1'b0;
        mtick[i] = 0;
      end else begin
        mtick[i]++;
        if (mtick[i] == per(i)) begin
          mtick[i] = 0;
          if (room) put = 1'b1;
          else      mpend[i] = 1'b1;
        end
      end
    end else if (en[i]) begin
      mrun[i]  = 1'b1;
      mtick[i] = 0;
    end
    if (pop) void'(mq[i].pop_front());
    if (put) begin
      mq[i].push_back(mseq[i]);
      mseq[i] = (mseq[i] + 1) % 16;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mq[i].delete();
        mseq[i]  = 0;
        mtick[i] = 0;
        mrun[i]  = 1'b0;
        mpend[i] = 1'b0;
      end else begin
        mstep(i);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.valid", i), int'(vld[i]),
            int'(mq[i].size() != 0));
        chk($sformatf("u%0d.count", i), int'(cnt[i]),
            mq[i].size());
        chk($sformatf("u%0d.stall", i), int'(stl[i]),
            int'(mpend[i]));
        if (mq[i].size() != 0)
          chk($sformatf("u%0d.data", i), int'(dat[i]),
              mq[i][0]);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  int got [$];

  initial begin
    tick(2);
    chk("rst.valid", int'(vld[0]), 0);
    chk("rst.count", int'(cnt[0]), 0);
    chk("rst.stall", int'(stl[0]), 0);
    chk("rst.data",  int'(dat[0]), 0);
    reset = 1'b0;

    en[0] = 1'b1; rdy[0] = 1'b1;
    tick(1);
    tick(2);
    chk("ss.gap0", int'(vld[0]), 0);
    tick(1);
    chk("ss.v0", int'(vld[0]), 1);
    chk("ss.d0", int'(dat[0]), 0);
    chk("ss.c0", int'(cnt[0]), 1);
    tick(1);
    chk("ss.drain", int'(cnt[0]), 0);
    tick(2);
    chk("ss.d1", int'(dat[0]), 1);
    tick(3);
    chk("ss.d2", int'(dat[0]), 2);
    chk("ss.stall", int'(stl[0]), 0);

    rst_pulse();
    en[0] = 1'b1; rdy[0] = 1'b0;
    tick(13);
    chk("bp.full", int'(cnt[0]), 4);
    chk("bp.head", int'(dat[0]), 0);
    chk("bp.nostall", int'(stl[0]), 0);
    tick(3);
    chk("bp.stall", int'(stl[0]), 1);
    chk("bp.hold", int'(cnt[0]), 4);
    rdy[0] = 1'b1;
    tick(1);
    rdy[0] = 1'b0;
    chk("bp.swap_cnt", int'(cnt[0]), 4);
    chk("bp.swap_stl", int'(stl[0]), 0);
    chk("bp.swap_head", int'(dat[0]), 1);
    tick(3);
    chk("bp.stall2", int'(stl[0]), 1);
    en[0] = 1'b0;
    tick(4);
    chk("ed.stall", int'(stl[0]), 1);
    rdy[0] = 1'b1;
    tick(1);
    rdy[0] = 1'b0;
    chk("ed.cnt", int'(cnt[0]), 4);
    chk("ed.stl", int'(stl[0]), 0);
    chk("ed.head", int'(dat[0]), 2);
    tick(10);
    chk("ed.idle", int'(cnt[0]), 4);
    rdy[0] = 1'b1;
    tick(4);
    chk("ed.empty", int'(cnt[0]), 0);

    rst_pulse();
    en[0] = 1'b1; rdy[0] = 1'b1;
    tick(1);
    got.delete();
    for (int k = 0; k < 55; k++) begin
      tick(1);
      if (vld[0]) got.push_back(int'(dat[0]));
    end
    chk("wrap.n", int'(got.size() >= 17), 1);
    for (int k = 0; k < 17 && k < got.size(); k++)
      chk($sformatf("wrap[%0d]", k), got[k], k % 16);
    en[0] = 1'b0;

    rst_pulse();
    en[1] = 1'b1; rdy[1] = 1'b1;
    tick(1);
    tick(1);
    chk("p1.v0", int'(vld[1]), 1);
    chk("p1.d0", int'(dat[1]), 0);
    tick(1);
    chk("p1.d1", int'(dat[1]), 1);
    chk("p1.c1", int'(cnt[1]), 1);
    tick(1);
    chk("p1.d2", int'(dat[1]), 2);
    for (int k = 0; k < 24; k++) begin
      rdy[1] = ~rdy[1];
      tick(1);
      chk("p1.bound", int'(cnt[1] <= 4), 1);
    end

    #2 reset = 1'b1;
    #1;
    chk("arst.valid", int'(vld), 0);
    chk("arst.count", int'(cnt), 0);
    chk("arst.stall", int'(stl), 0);
    chk("arst.data",  int'(dat), 0);
    #1 reset = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        en[i]  = ($urandom_range(0, 9) < 8);
        rdy[i] = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
